// File: rtl/transaction_control_pkg.sv
// Shared definitions for the coin-transfer responder: state encodings,
// player addresses and default widths.
package transaction_control_pkg;

  localparam int BAL_W_DEF  = 8;
  localparam int KEY_W_DEF  = 4;
  localparam int ADDR_W_DEF = 1;

  localparam logic P1_ADDR = 1'b0;
  localparam logic P2_ADDR = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_RD_SRC   = 4'd1,
    ST_WAIT_SRC = 4'd2,
    ST_CHECK    = 4'd3,
    ST_RD_DST   = 4'd4,
    ST_WAIT_DST = 4'd5,
    ST_WR_SRC   = 4'd6,
    ST_WR_DST   = 4'd7,
    ST_DONE     = 4'd8
  } state_e;

endpackage

// File: rtl/transaction_control_alu.sv
// Combinational balance arithmetic for one transfer: funds check,
// sender debit and saturating receiver credit.
module tx_balance_alu #(
  parameter int BAL_W = 8
) (
  input  logic [BAL_W-1:0] src_bal_i,
  input  logic [BAL_W-1:0] dst_bal_i,
  input  logic [BAL_W-1:0] amount_i,
  output logic             funds_ok_o,
  output logic [BAL_W-1:0] src_new_o,
  output logic [BAL_W-1:0] dst_new_o
);

  // Credit clamps at the all-ones balance instead of wrapping.
  function automatic logic [BAL_W-1:0] sat_add(input logic [BAL_W-1:0] a,
                                               input logic [BAL_W-1:0] b);
    logic [BAL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[BAL_W] ? {BAL_W{1'b1}} : sum[BAL_W-1:0];
  endfunction

  assign funds_ok_o = (src_bal_i >= amount_i);
  assign src_new_o  = src_bal_i - amount_i;
  assign dst_new_o  = sat_add(dst_bal_i, amount_i);

endmodule

// File: rtl/transaction_control.sv
// Executes one coin transfer between the two balance RAM entries in response
// to the main controller's start/finished handshake.
module transaction_control
  import transaction_control_pkg::*;
#(
  parameter int BAL_W  = BAL_W_DEF,
  parameter int KEY_W  = KEY_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              reset_others,
  input  logic              start_transaction,
  input  logic              sender_sel,
  input  logic [BAL_W-1:0]  amount,
  input  logic [KEY_W-1:0]  key,
  input  logic [KEY_W-1:0]  expected_key,
  input  logic [BAL_W-1:0]  mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BAL_W-1:0]  mem_wdata,
  output logic              mem_we,
  output logic              finished_transaction,
  output logic              tx_ok,
  output logic              err_key,
  output logic              err_funds
);

  state_e state_q, state_d;
  logic   tx_ok_q, tx_ok_d;
  logic   err_key_q, err_key_d;
  logic   err_funds_q, err_funds_d;

  logic [BAL_W-1:0] amount_q;
  logic [KEY_W-1:0] key_q;
  logic [KEY_W-1:0] exp_key_q;
  logic             sel_q;
  logic [BAL_W-1:0] src_bal_q;
  logic [BAL_W-1:0] dst_bal_q;

  logic             latch;
  logic             funds_ok;
  logic [BAL_W-1:0] src_new;
  logic [BAL_W-1:0] dst_new;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;

  assign latch    = (state_q == ST_IDLE) && start_transaction;
  assign src_addr = sel_q ? ADDR_W'(P2_ADDR) : ADDR_W'(P1_ADDR);
  assign dst_addr = sel_q ? ADDR_W'(P1_ADDR) : ADDR_W'(P2_ADDR);

  tx_balance_alu #(
    .BAL_W(BAL_W)
  ) u_alu (
    .src_bal_i  (src_bal_q),
    .dst_bal_i  (dst_bal_q),
    .amount_i   (amount_q),
    .funds_ok_o (funds_ok),
    .src_new_o  (src_new),
    .dst_new_o  (dst_new)
  );

  // Either active-low clear returns the block to a quiet IDLE.
  always_ff @(posedge clock) begin
    if (!resetn || !reset_others) begin
      state_q     <= ST_IDLE;
      tx_ok_q     <= 1'b0;
      err_key_q   <= 1'b0;
      err_funds_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_ok_q     <= tx_ok_d;
      err_key_q   <= err_key_d;
      err_funds_q <= err_funds_d;
    end
  end

  // Transaction operands are frozen at start so later input changes are ignored.
  always_ff @(posedge clock) begin
    if (latch) begin
      amount_q  <= amount;
      key_q     <= key;
      exp_key_q <= expected_key;
      sel_q     <= sender_sel;
    end
    if (state_q == ST_WAIT_SRC) src_bal_q <= mem_rdata;
    if (state_q == ST_WAIT_DST) dst_bal_q <= mem_rdata;
  end

  always_comb begin
    state_d     = state_q;
    tx_ok_d     = tx_ok_q;
    err_key_d   = err_key_q;
    err_funds_d = err_funds_q;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_transaction) begin
          tx_ok_d     = 1'b0;
          err_key_d   = 1'b0;
          err_funds_d = 1'b0;
          state_d     = ST_RD_SRC;
        end
      end
      ST_RD_SRC: begin
        mem_addr = src_addr;
        state_d  = ST_WAIT_SRC;
      end
      ST_WAIT_SRC: state_d = ST_CHECK;
      ST_CHECK: begin
        if (key_q != exp_key_q) begin
          err_key_d = 1'b1;
          state_d   = ST_DONE;
        end else if (!funds_ok) begin
          err_funds_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_RD_DST;
        end
      end
      ST_RD_DST: begin
        mem_addr = dst_addr;
        state_d  = ST_WAIT_DST;
      end
      ST_WAIT_DST: state_d = ST_WR_SRC;
      ST_WR_SRC: begin
        mem_addr  = src_addr;
        mem_wdata = src_new;
        mem_we    = 1'b1;
        state_d   = ST_WR_DST;
      end
      ST_WR_DST: begin
        mem_addr  = dst_addr;
        mem_wdata = dst_new;
        mem_we    = 1'b1;
        tx_ok_d   = 1'b1;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        if (!start_transaction) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign finished_transaction = (state_q == ST_DONE);
  assign tx_ok                = tx_ok_q;
  assign err_key              = err_key_q;
  assign err_funds            = err_funds_q;

endmodule

// File: tb/tb_transaction_control.sv
// Scoreboard bench for transaction_control: a two-entry RAM model, a driver
// that queues expected writes/completions, and a monitor that checks them.
module tb_transaction_control;

  localparam int BAL_W  = 8;
  localparam int KEY_W  = 4;
  localparam int ADDR_W = 1;

  logic              clock = 1'b0;
  logic              resetn;
  logic              reset_others;
  logic              start_transaction;
  logic              sender_sel;
  logic [BAL_W-1:0]  amount;
  logic [KEY_W-1:0]  key;
  logic [KEY_W-1:0]  expected_key;
  logic [BAL_W-1:0]  mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [BAL_W-1:0]  mem_wdata;
  logic              mem_we;
  logic              finished_transaction;
  logic              tx_ok;
  logic              err_key;
  logic              err_funds;

  always #5 clock = ~clock;

  transaction_control #(
    .BAL_W(BAL_W), .KEY_W(KEY_W), .ADDR_W(ADDR_W)
  ) dut (
    .clock                (clock),
    .resetn               (resetn),
    .reset_others         (reset_others),
    .start_transaction    (start_transaction),
    .sender_sel           (sender_sel),
    .amount               (amount),
    .key                  (key),
    .expected_key         (expected_key),
    .mem_rdata            (mem_rdata),
    .mem_addr             (mem_addr),
    .mem_wdata            (mem_wdata),
    .mem_we               (mem_we),
    .finished_transaction (finished_transaction),
    .tx_ok                (tx_ok),
    .err_key              (err_key),
    .err_funds            (err_funds)
  );

  // Synchronous-read RAM with a bench-side preload port.
  logic [BAL_W-1:0] ram [0:1];
  logic             pre_en = 1'b0;
  logic [BAL_W-1:0] pre0 = '0, pre1 = '0;

  always @(posedge clock) begin
    if (pre_en) begin
      ram[0] <= pre0;
      ram[1] <= pre1;
    end else if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clock) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [BAL_W-1:0]  data;
  } wr_t;

  typedef struct {
    int       t0;
    int       lat;
    logic [2:0] flags;
  } done_t;

  wr_t   wq[$];
  done_t dq[$];
  wr_t   w_pop;
  done_t d_pop;
  logic  fin_prev = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write and every completion is matched against the queues.
  always @(negedge clock) begin
    if (mem_we) begin
      if (finished_transaction) chk("write_in_done", 1, 0);
      if (wq.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        w_pop = wq.pop_front();
        chk("wr_addr", int'(mem_addr), int'(w_pop.addr));
        chk("wr_data", int'(mem_wdata), int'(w_pop.data));
      end
    end
    if (finished_transaction && !fin_prev) begin
      if (dq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        d_pop = dq.pop_front();
        chk("latency", cyc - d_pop.t0, d_pop.lat);
        chk("flags{ok,key,funds}", int'({tx_ok, err_key, err_funds}), int'(d_pop.flags));
      end
    end
    fin_prev = finished_transaction;
  end

  task automatic push_w(input logic a, input logic [BAL_W-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
  endtask

  task automatic set_bal(input logic [BAL_W-1:0] p1, input logic [BAL_W-1:0] p2);
    @(negedge clock);
    pre0 = p1; pre1 = p2; pre_en = 1'b1;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  task automatic chk_ram(input string name, input int p1, input int p2);
    chk({name, "_p1"}, int'(ram[0]), p1);
    chk({name, "_p2"}, int'(ram[1]), p2);
  endtask

  task automatic run_tx(input logic s, input logic [BAL_W-1:0] a,
                        input logic [KEY_W-1:0] k, input logic [KEY_W-1:0] ek,
                        input int lat, input logic [2:0] fl, input int hold);
    done_t e;
    int    ok;
    @(negedge clock);
    sender_sel = s; amount = a; key = k; expected_key = ek;
    start_transaction = 1'b1;
    e.t0 = cyc; e.lat = lat; e.flags = fl;
    dq.push_back(e);
    @(posedge clock);
    #1;
    sender_sel = ~s; amount = ~a; key = ~k; expected_key = ek + 4'd1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (finished_transaction) begin
        ok = 1;
        break;
      end
    end
    chk("done_seen", ok, 1);
    chk("writes_drained", wq.size(), 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      chk("fin_held", int'(finished_transaction), 1);
    end
    start_transaction = 1'b0;
    @(negedge clock);
    chk("fin_released", int'(finished_transaction), 0);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_fin"},   int'(finished_transaction), 0);
    chk({name, "_ok"},    int'(tx_ok), 0);
    chk({name, "_ekey"},  int'(err_key), 0);
    chk({name, "_efund"}, int'(err_funds), 0);
    chk({name, "_we"},    int'(mem_we), 0);
    chk({name, "_addr"},  int'(mem_addr), 0);
    chk({name, "_wdata"}, int'(mem_wdata), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; reset_others = 1'b1; start_transaction = 1'b0;
    sender_sel = 1'b0; amount = '0; key = '0; expected_key = '0;
    set_bal(8'd0, 8'd0);
    repeat (2) @(negedge clock);
    chk_quiet("reset");
    resetn = 1'b1;
    @(negedge clock);
    chk_quiet("post_reset");

    // Basic success: P1 pays P2 15.
    set_bal(8'd50, 8'd20);
    push_w(1'b0, 8'd35);
    push_w(1'b1, 8'd35);
    run_tx(1'b0, 8'd15, 4'hA, 4'hA, 8, 3'b100, 0);
    chk_ram("basic", 35, 35);
    repeat (2) @(negedge clock);
    chk("tx_ok_sticky", int'(tx_ok), 1);

    // Key mismatch; also key mismatch with insufficient funds reports key only.
    run_tx(1'b0, 8'd5, 4'h3, 4'h5, 4, 3'b010, 0);
    chk_ram("badkey", 35, 35);
    run_tx(1'b0, 8'd200, 4'h3, 4'h5, 4, 3'b010, 0);
    chk_ram("badkey_funds", 35, 35);

    // P2 pays P1: one short, then exactly the balance.
    set_bal(8'd35, 8'd10);
    run_tx(1'b1, 8'd11, 4'h7, 4'h7, 4, 3'b001, 0);
    chk_ram("funds", 35, 10);
    push_w(1'b1, 8'd0);
    push_w(1'b0, 8'd45);
    run_tx(1'b1, 8'd10, 4'h7, 4'h7, 8, 3'b100, 0);
    chk_ram("exact", 45, 0);

    // Saturating credit.
    set_bal(8'd250, 8'd250);
    push_w(1'b0, 8'd50);
    push_w(1'b1, 8'd255);
    run_tx(1'b0, 8'd200, 4'h1, 4'h1, 8, 3'b100, 0);
    chk_ram("sat", 50, 255);

    // Zero amount rewrites both balances unchanged.
    set_bal(8'd7, 8'd9);
    push_w(1'b0, 8'd7);
    push_w(1'b1, 8'd9);
    run_tx(1'b0, 8'd0, 4'hF, 4'hF, 8, 3'b100, 0);
    chk_ram("zero", 7, 9);

    // Start held 5 cycles in DONE: one transfer only.
    set_bal(8'd100, 8'd0);
    push_w(1'b0, 8'd90);
    push_w(1'b1, 8'd10);
    run_tx(1'b0, 8'd10, 4'h2, 4'h2, 8, 3'b100, 5);
    chk_ram("hold", 90, 10);

    // Soft clear in WAIT_DST: abort before any write.
    set_bal(8'd60, 8'd60);
    @(negedge clock);
    sender_sel = 1'b0; amount = 8'd20; key = 4'h4; expected_key = 4'h4;
    start_transaction = 1'b1;
    repeat (5) @(posedge clock);
    @(negedge clock);
    reset_others = 1'b0;
    start_transaction = 1'b0;
    @(negedge clock);
    chk_quiet("abort");
    reset_others = 1'b1;
    repeat (8) @(negedge clock);
    chk("abort_idle_fin", int'(finished_transaction), 0);
    chk_ram("abort", 60, 60);

    push_w(1'b0, 8'd40);
    push_w(1'b1, 8'd80);
    run_tx(1'b0, 8'd20, 4'h4, 4'h4, 8, 3'b100, 0);
    chk_ram("after_abort", 40, 80);

    repeat (3) @(negedge clock);
    chk("pending_writes", wq.size(), 0);
    chk("pending_dones", dq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
